instruction_fetch: RTL and testbench

//  Fetches each instruction from 8-bit byte-wide program memory and presents it to the decoder.

---
 rtl/instruction_fetch.sv | 156 +++++++++++++++
 tb/tb_instruction_fetch.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Fetches 2- or 3-byte instructions from byte-wide program
//               memory (high byte first, optional data byte) and holds
//               {inst, data, pc} stable for the decoder while inst_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic        mem_ready,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] inst,
    output logic [7:0]  data,
    output logic        inst_valid,
    output logic [15:0] pc,
    input  logic        advance,
    input  logic        pc_load,
    input  logic [15:0] pc_in
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FETCH_HI   = 3'd1,
        FETCH_LO   = 3'd2,
        FETCH_DATA = 3'd3,
        VALID      = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_pc;
    logic [15:0] r_mem_addr;
    logic [15:0] r_inst;
    logic [7:0]  r_data;
    logic        r_has_data;
    logic        w_need_data;
    logic [15:0] w_len;

    // The data-byte decision depends only on the high byte, already captured
    // by the time the low byte arrives: class 2'b10 with sub-op bits 10:9 = 01.
    assign w_need_data = (r_inst[15:14] == 2'b10) && (r_inst[10:9] == 2'b01);
    assign w_len       = r_has_data ? 16'd3 : 16'd2;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs; a branch redirect overrides everything
    always_comb begin
        w_state_next = r_state;
        mem_rd       = 1'b0;
        inst_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_next = FETCH_HI;
            end
            FETCH_HI: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    w_state_next = FETCH_LO;
                end
            end
            FETCH_LO: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    w_state_next = w_need_data ? FETCH_DATA : VALID;
                end
            end
            FETCH_DATA: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    w_state_next = VALID;
                end
            end
            VALID: begin
                inst_valid = 1'b1;
                if (advance) begin
                    w_state_next = FETCH_HI;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (pc_load) begin
            w_state_next = FETCH_HI;
        end
    end

    // Datapath: byte capture, read address sequencing and PC update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_mem_addr <= RESET_PC;
            r_inst     <= 16'h0000;
            r_data     <= 8'h00;
            r_has_data <= 1'b0;
        end else if (pc_load) begin
            // Any byte returned in this cycle belongs to the abandoned stream
            r_pc       <= pc_in;
            r_mem_addr <= pc_in;
        end else begin
            case (r_state)
                FETCH_HI: begin
                    if (mem_ready) begin
                        r_inst[15:8] <= mem_rdata;
                        r_mem_addr   <= r_pc + 16'd1;
                    end
                end
                FETCH_LO: begin
                    if (mem_ready) begin
                        r_inst[7:0] <= mem_rdata;
                        if (w_need_data) begin
                            r_mem_addr <= r_pc + 16'd2;
                            r_has_data <= 1'b1;
                        end else begin
                            r_data     <= 8'h00;
                            r_has_data <= 1'b0;
                        end
                    end
                end
                FETCH_DATA: begin
                    if (mem_ready) begin
                        r_data <= mem_rdata;
                    end
                end
                VALID: begin
                    if (advance) begin
                        r_pc       <= r_pc + w_len;
                        r_mem_addr <= r_pc + w_len;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr = r_mem_addr;
    assign inst     = r_inst;
    assign data     = r_data;
    assign pc       = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Scoreboard bench for instruction_fetch with a byte memory
//               responder, read-address and instruction expectation queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    typedef struct packed {
        logic [15:0] inst;
        logic [7:0]  data;
        logic [15:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_ready;
    logic [7:0]  mem_rdata;
    logic [15:0] inst;
    logic [7:0]  data;
    logic        inst_valid;
    logic [15:0] pc;
    logic        advance;
    logic        pc_load;
    logic [15:0] pc_in;

    logic [7:0]  mem [0:65535];
    int          wait_n;
    int          vectors;
    int          miscompares;
    logic [15:0] q_addr [$];
    exp_t        q_inst [$];

    instruction_fetch #(.RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .inst       (inst),
        .data       (data),
        .inst_valid (inst_valid),
        .pc         (pc),
        .advance    (advance),
        .pc_load    (pc_load),
        .pc_in      (pc_in)
    );

    always #5 clk = ~clk;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!inst_valid && n < 200) begin
            tick();
            n++;
        end
        check16({name, "_valid_timeout"}, {15'd0, inst_valid}, 16'd1);
    endtask

    task automatic do_advance();
        advance = 1'b1;
        tick();
        advance = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] target, input logic with_adv);
        pc_load = 1'b1;
        pc_in   = target;
        advance = with_adv;
        tick();
        pc_load = 1'b0;
        advance = 1'b0;
    endtask

    task automatic expect_inst(input logic [15:0] i, input logic [7:0] d, input logic [15:0] p);
        exp_t e;
        e.inst = i;
        e.data = d;
        e.pc   = p;
        q_inst.push_back(e);
    endtask

    // Memory responder: answers after wait_n wait cycles per byte
    initial begin
        int          cnt;
        logic [15:0] last_addr;
        logic        last_rd;
        cnt       = 0;
        last_addr = 16'h0000;
        last_rd   = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (!mem_rd) begin
                mem_ready = 1'b0;
                cnt       = 0;
            end else begin
                if (mem_addr != last_addr || !last_rd) cnt = 0;
                if (cnt == wait_n) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem[mem_addr];
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = 8'hXX;
                end
                cnt++;
            end
            last_addr = mem_addr;
            last_rd   = mem_rd;
        end
    end

    // Monitor: read handshakes, new valid instructions, address stability
    initial begin
        logic        prev_valid;
        logic        prev_rd;
        logic        prev_ready;
        logic        prev_load;
        logic        prev_rst;
        logic [15:0] prev_addr;
        logic [15:0] ea;
        exp_t        e;
        prev_valid = 1'b0;
        prev_rd    = 1'b0;
        prev_ready = 1'b0;
        prev_load  = 1'b0;
        prev_rst   = 1'b1;
        prev_addr  = 16'h0000;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_rd && mem_ready) begin
                    if (q_addr.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL read_addr: unexpected read at %h, expected none", mem_addr);
                    end else begin
                        ea = q_addr.pop_front();
                        check16("read_addr", mem_addr, ea);
                    end
                end
                if (prev_rd && !prev_ready && !prev_load && !prev_rst) begin
                    check16("wait_rd_held", {15'd0, mem_rd}, 16'd1);
                    check16("wait_addr_held", mem_addr, prev_addr);
                end
                if (inst_valid && !prev_valid) begin
                    if (q_inst.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL inst_valid: unexpected inst %h at pc %h, expected none", inst, pc);
                    end else begin
                        e = q_inst.pop_front();
                        check16("inst", inst, e.inst);
                        check16("data", {8'h00, data}, {8'h00, e.data});
                        check16("pc", pc, e.pc);
                    end
                end
            end
            prev_valid = inst_valid;
            prev_rd    = mem_rd;
            prev_ready = mem_ready;
            prev_load  = pc_load;
            prev_rst   = rst;
            prev_addr  = mem_addr;
        end
    end

    // Stimulus
    initial begin
        int n;
        vectors     = 0;
        miscompares = 0;
        wait_n      = 0;
        rst         = 1'b1;
        advance     = 1'b0;
        pc_load     = 1'b0;
        pc_in       = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0000] = 8'h80; mem[16'h0001] = 8'h2A;
        mem[16'h0002] = 8'h82; mem[16'h0003] = 8'h00; mem[16'h0004] = 8'h5C;
        mem[16'h0005] = 8'h40; mem[16'h0006] = 8'h11;
        mem[16'h0010] = 8'hC0; mem[16'h0011] = 8'h00;
        mem[16'h0012] = 8'hAA; mem[16'h0013] = 8'hBB;
        mem[16'h0100] = 8'h81; mem[16'h0101] = 8'hFF;
        mem[16'h0102] = 8'hA2; mem[16'h0103] = 8'h77; mem[16'h0104] = 8'hEE;
        mem[16'h0200] = 8'h80; mem[16'h0201] = 8'h04;
        mem[16'hFFFF] = 8'h80;

        // Reset state
        repeat (2) @(negedge clk);
        check16("rst_pc", pc, 16'h0000);
        check16("rst_mem_addr", mem_addr, 16'h0000);
        check16("rst_inst", inst, 16'h0000);
        check16("rst_data", {8'h00, data}, 16'h0000);
        check16("rst_mem_rd", {15'd0, mem_rd}, 16'd0);
        check16("rst_inst_valid", {15'd0, inst_valid}, 16'd0);

        // Two-byte instruction at 0: one idle cycle, then two single-cycle reads
        q_addr.push_back(16'h0000);
        q_addr.push_back(16'h0001);
        expect_inst(16'h802A, 8'h00, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        while (!inst_valid && n < 20) begin
            tick();
            n++;
        end
        check16("valid_latency_edges", n[15:0], 16'd3);

        // Data-form instruction at 2: three reads, advance steps pc by 3
        q_addr.push_back(16'h0002);
        q_addr.push_back(16'h0003);
        q_addr.push_back(16'h0004);
        expect_inst(16'h8200, 8'h5C, 16'h0002);
        do_advance();
        wait_valid("data_form");

        // Wait states: 3 per byte, so 8 fetch cycles for a two-byte instruction
        wait_n = 3;
        q_addr.push_back(16'h0005);
        q_addr.push_back(16'h0006);
        expect_inst(16'h4011, 8'h00, 16'h0005);
        do_advance();
        n = 0;
        while (!inst_valid && n < 50) begin
            tick();
            n++;
        end
        check16("wait_fetch_edges", n[15:0], 16'd8);
        wait_n = 0;

        // Branch to 0010
        q_addr.push_back(16'h0010);
        q_addr.push_back(16'h0011);
        expect_inst(16'hC000, 8'h00, 16'h0010);
        do_load(16'h0010, 1'b0);
        wait_valid("branch_0010");

        // pc_load together with advance: load wins, no fetch at 0012
        q_addr.push_back(16'h0100);
        q_addr.push_back(16'h0101);
        expect_inst(16'h81FF, 8'h00, 16'h0100);
        do_load(16'h0100, 1'b1);
        check16("load_beats_advance_addr", mem_addr, 16'h0100);
        check16("load_beats_advance_pc", pc, 16'h0100);
        wait_valid("branch_0100");

        // pc_load during FETCH_LO with a coincident ready byte
        q_addr.push_back(16'h0102);
        q_addr.push_back(16'h0103);
        do_advance();
        n = 0;
        while (!(mem_rd && mem_addr == 16'h0103) && n < 20) begin
            tick();
            n++;
        end
        check16("reach_fetch_lo_addr", mem_addr, 16'h0103);
        q_addr.push_back(16'h0200);
        q_addr.push_back(16'h0201);
        expect_inst(16'h8004, 8'h00, 16'h0200);
        do_load(16'h0200, 1'b0);
        check16("abandon_valid_low", {15'd0, inst_valid}, 16'd0);
        check16("abandon_refetch_addr", mem_addr, 16'h0200);
        wait_valid("branch_0200");

        // Address wrap FFFF -> 0000, then pc+2 wraps to 0001
        mem[16'h0000] = 8'h01;
        q_addr.push_back(16'hFFFF);
        q_addr.push_back(16'h0000);
        expect_inst(16'h8001, 8'h00, 16'hFFFF);
        do_load(16'hFFFF, 1'b0);
        wait_valid("wrap_ffff");
        q_addr.push_back(16'h0001);
        q_addr.push_back(16'h0002);
        expect_inst(16'h2A82, 8'h00, 16'h0001);
        do_advance();
        check16("wrap_pc_after_advance", pc, 16'h0001);
        wait_valid("wrap_0001");

        // Reset in the middle of a waited read at 0003
        wait_n = 3;
        do_advance();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check16("midrst_mem_rd", {15'd0, mem_rd}, 16'd0);
        check16("midrst_pc", pc, 16'h0000);
        check16("midrst_mem_addr", mem_addr, 16'h0000);
        check16("midrst_inst", inst, 16'h0000);
        wait_n = 0;
        mem[16'h0000] = 8'h80;
        q_addr.push_back(16'h0000);
        q_addr.push_back(16'h0001);
        expect_inst(16'h802A, 8'h00, 16'h0000);
        tick();
        rst = 1'b0;
        wait_valid("after_midrst");

        // Advance ignored outside VALID: pulse during the next fetch
        q_addr.push_back(16'h0002);
        q_addr.push_back(16'h0003);
        q_addr.push_back(16'h0004);
        expect_inst(16'h8200, 8'h5C, 16'h0002);
        do_advance();
        do_advance();
        check16("advance_ignored_pc", pc, 16'h0002);
        wait_valid("after_ignored_advance");

        repeat (3) tick();
        check16("pending_reads", q_addr.size()[15:0], 16'd0);
        check16("pending_insts", q_inst.size()[15:0], 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
